// File: rtl/regex_cpu_memory_arbiter_if.sv
// Bundle of the per-CPU fetch ports, the host program-load port and the BRAM port
// seen by the regex_cpu instruction memory arbiter.
interface regex_cpu_memory_arbiter_if #(
  parameter int NUM_CPUS          = 4,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11
);
  logic [NUM_CPUS-1:0]                   cpu_memory_valid;
  logic [NUM_CPUS*MEMORY_ADDR_WIDTH-1:0] cpu_memory_addr;
  logic [NUM_CPUS-1:0]                   cpu_memory_ready;
  logic [NUM_CPUS*MEMORY_WIDTH-1:0]      cpu_memory_data;
  logic                                  host_wr_en;
  logic [MEMORY_ADDR_WIDTH-1:0]          host_wr_addr;
  logic [MEMORY_WIDTH-1:0]               host_wr_data;
  logic                                  bram_en;
  logic                                  bram_we;
  logic [MEMORY_ADDR_WIDTH-1:0]          bram_addr;
  logic [MEMORY_WIDTH-1:0]               bram_wdata;
  logic [MEMORY_WIDTH-1:0]               bram_rdata;

  modport master (
    output cpu_memory_valid, cpu_memory_addr, host_wr_en, host_wr_addr, host_wr_data, bram_rdata,
    input  cpu_memory_ready, cpu_memory_data, bram_en, bram_we, bram_addr, bram_wdata
  );

  modport slave (
    input  cpu_memory_valid, cpu_memory_addr, host_wr_en, host_wr_addr, host_wr_data, bram_rdata,
    output cpu_memory_ready, cpu_memory_data, bram_en, bram_we, bram_addr, bram_wdata
  );
endinterface

// File: rtl/regex_cpu_memory_arbiter.sv
// Round-robin arbiter sharing one single-port instruction BRAM between NUM_CPUS fetch ports,
// with a one-cycle lockout of the last served CPU and absolute host write priority.
module regex_cpu_memory_arbiter #(
  parameter int NUM_CPUS          = 4,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11
) (
  input logic                     clk,
  input logic                     rst,
  regex_cpu_memory_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;
  typedef logic [PTR_W-1:0] idx_t;

  idx_t                    ptr;
  idx_t                    ret_id;
  idx_t                    grant_id;
  idx_t                    scan_id;
  logic                    grant_valid;
  logic                    ret_valid;
  logic                    post_reset;
  logic                    host_active;
  logic [NUM_CPUS-1:0]     lockout;
  logic [NUM_CPUS-1:0]     eligible;
  logic [NUM_CPUS-1:0]     grant_onehot;
  logic [MEMORY_WIDTH-1:0] held [NUM_CPUS];

  function automatic idx_t wrap_idx(input idx_t base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_CPUS) sum = sum - NUM_CPUS;
    return idx_t'(sum);
  endfunction

  assign host_active = bus.host_wr_en && !rst;
  assign eligible    = bus.cpu_memory_valid & ~lockout;

  // Grants are suppressed in the reset cycle and the cycle after it.
  always_comb begin
    grant_valid  = 1'b0;
    grant_id     = '0;
    scan_id      = '0;
    grant_onehot = '0;
    if (!rst && !post_reset && !host_active) begin
      for (int k = 0; k < NUM_CPUS; k++) begin
        scan_id = wrap_idx(ptr, k);
        if (!grant_valid && eligible[scan_id]) begin
          grant_valid = 1'b1;
          grant_id    = scan_id;
        end
      end
    end
    if (grant_valid) grant_onehot[grant_id] = 1'b1;
  end

  always_comb begin
    bus.cpu_memory_ready = grant_onehot;
    bus.bram_en          = 1'b0;
    bus.bram_we          = 1'b0;
    bus.bram_addr        = '0;
    bus.bram_wdata       = '0;
    if (host_active) begin
      bus.bram_en    = 1'b1;
      bus.bram_we    = 1'b1;
      bus.bram_addr  = bus.host_wr_addr;
      bus.bram_wdata = bus.host_wr_data;
    end else if (grant_valid) begin
      bus.bram_en   = 1'b1;
      bus.bram_addr = bus.cpu_memory_addr[int'(grant_id)*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
    end
  end

  // The returning slice bypasses the holding register so data appears the cycle after ready.
  always_comb begin
    bus.cpu_memory_data = '0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      if (ret_valid && !rst && ret_id == idx_t'(i))
        bus.cpu_memory_data[i*MEMORY_WIDTH +: MEMORY_WIDTH] = bus.bram_rdata;
      else
        bus.cpu_memory_data[i*MEMORY_WIDTH +: MEMORY_WIDTH] = held[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      lockout    <= '0;
      ret_valid  <= 1'b0;
      ret_id     <= '0;
      post_reset <= 1'b1;
      for (int i = 0; i < NUM_CPUS; i++) held[i] <= '0;
    end else begin
      post_reset <= 1'b0;
      if (ret_valid) held[ret_id] <= bus.bram_rdata;
      if (grant_valid) begin
        ptr       <= wrap_idx(grant_id, 1);
        lockout   <= grant_onehot;
        ret_valid <= 1'b1;
        ret_id    <= grant_id;
      end else begin
        lockout   <= '0;
        ret_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_regex_cpu_memory_arbiter.sv
// Directed bench for regex_cpu_memory_arbiter: a behavioural BRAM is loaded through the
// host port, then fetch ordering, lockout, host priority, wrap and reset are exercised.
module tb_regex_cpu_memory_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [15:0] mem [2048];

  regex_cpu_memory_arbiter_if #(.NUM_CPUS(4), .MEMORY_WIDTH(16), .MEMORY_ADDR_WIDTH(11)) bus ();

  regex_cpu_memory_arbiter #(.NUM_CPUS(4), .MEMORY_WIDTH(16), .MEMORY_ADDR_WIDTH(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Single-port BRAM with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.bram_en) begin
      if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_wdata;
      else             bus.bram_rdata <= mem[bus.bram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] valid);
    bus.cpu_memory_valid = valid;
    #1;
  endtask

  task automatic setAddr(input int cpu, input logic [10:0] addr);
    bus.cpu_memory_addr[cpu*11 +: 11] = addr;
  endtask

  function automatic logic [15:0] dataOf(input int cpu);
    return bus.cpu_memory_data[cpu*16 +: 16];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic hostWrite(input logic [10:0] addr, input logic [15:0] data);
    bus.host_wr_en   = 1'b1;
    bus.host_wr_addr = addr;
    bus.host_wr_data = data;
    #1;
    checkOutput("preload_we", {31'd0, bus.bram_we}, 32'd1);
    tick();
    bus.host_wr_en = 1'b0;
  endtask

  initial begin
    rst                  = 1'b1;
    bus.cpu_memory_valid = '0;
    bus.cpu_memory_addr  = '0;
    bus.host_wr_en       = 1'b0;
    bus.host_wr_addr     = '0;
    bus.host_wr_data     = '0;

    // Reset cycle and the cycle after it: requests present but never granted.
    tick();
    applyStimulus(4'b1111);
    checkOutput("rst_ready", {28'd0, bus.cpu_memory_ready}, 32'd0);
    checkOutput("rst_bram_en", {31'd0, bus.bram_en}, 32'd0);
    checkOutput("rst_bram_we", {31'd0, bus.bram_we}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", {28'd0, bus.cpu_memory_ready}, 32'd0);
    checkOutput("post_rst_data0", {16'd0, dataOf(0)}, 32'd0);
    checkOutput("post_rst_data3", {16'd0, dataOf(3)}, 32'd0);
    applyStimulus(4'b0000);
    tick();

    hostWrite(11'h010, 16'h1111);
    hostWrite(11'h020, 16'h2222);
    hostWrite(11'h030, 16'h3333);
    hostWrite(11'h040, 16'h4444);
    hostWrite(11'h050, 16'h5555);
    hostWrite(11'h062, 16'h1A41);

    // All four CPUs request continuously from ptr=0.
    setAddr(0, 11'h010); setAddr(1, 11'h020); setAddr(2, 11'h030); setAddr(3, 11'h040);
    applyStimulus(4'b1111);
    checkOutput("rr_c0_ready", {28'd0, bus.cpu_memory_ready}, 32'h1);
    checkOutput("rr_c0_addr", {21'd0, bus.bram_addr}, 32'h010);
    tick(); #1;
    checkOutput("rr_c1_ready", {28'd0, bus.cpu_memory_ready}, 32'h2);
    checkOutput("rr_c1_data0", {16'd0, dataOf(0)}, 32'h1111);
    tick(); #1;
    checkOutput("rr_c2_ready", {28'd0, bus.cpu_memory_ready}, 32'h4);
    checkOutput("rr_c2_data1", {16'd0, dataOf(1)}, 32'h2222);
    tick(); #1;
    checkOutput("rr_c3_ready", {28'd0, bus.cpu_memory_ready}, 32'h8);
    checkOutput("rr_c3_data2", {16'd0, dataOf(2)}, 32'h3333);
    tick(); #1;
    checkOutput("rr_c4_ready", {28'd0, bus.cpu_memory_ready}, 32'h1);
    checkOutput("rr_c4_data3", {16'd0, dataOf(3)}, 32'h4444);
    tick();
    applyStimulus(4'b0000);
    checkOutput("rr_c5_ready", {28'd0, bus.cpu_memory_ready}, 32'h0);
    checkOutput("rr_c5_data0", {16'd0, dataOf(0)}, 32'h1111);
    tick();

    // Lockout: CPU1 alone holds valid for three cycles.
    setAddr(1, 11'h050);
    applyStimulus(4'b0010);
    checkOutput("lock_t0_ready", {28'd0, bus.cpu_memory_ready}, 32'h2);
    tick(); #1;
    checkOutput("lock_t1_ready", {28'd0, bus.cpu_memory_ready}, 32'h0);
    checkOutput("lock_t1_en", {31'd0, bus.bram_en}, 32'd0);
    checkOutput("lock_t1_data1", {16'd0, dataOf(1)}, 32'h5555);
    tick(); #1;
    checkOutput("lock_t2_ready", {28'd0, bus.cpu_memory_ready}, 32'h2);
    tick();
    applyStimulus(4'b0000);
    checkOutput("lock_t3_data1", {16'd0, dataOf(1)}, 32'h5555);
    tick();

    // Single fetch by CPU2.
    setAddr(2, 11'h062);
    applyStimulus(4'b0100);
    checkOutput("single_ready", {28'd0, bus.cpu_memory_ready}, 32'h4);
    checkOutput("single_addr", {21'd0, bus.bram_addr}, 32'h062);
    checkOutput("single_we", {31'd0, bus.bram_we}, 32'd0);
    tick();
    applyStimulus(4'b0000);
    checkOutput("single_t1_ready", {28'd0, bus.cpu_memory_ready}, 32'h0);
    checkOutput("single_t1_data2", {16'd0, dataOf(2)}, 32'h1A41);
    tick(); #1;
    checkOutput("single_t2_data2", {16'd0, dataOf(2)}, 32'h1A41);
    checkOutput("single_t2_en", {31'd0, bus.bram_en}, 32'd0);

    // Wrap: ptr=3 with CPU3 and CPU0 requesting.
    setAddr(3, 11'h040); setAddr(0, 11'h020);
    applyStimulus(4'b1001);
    checkOutput("wrap_a_ready", {28'd0, bus.cpu_memory_ready}, 32'h8);
    tick();
    applyStimulus(4'b0001);
    checkOutput("wrap_b_ready", {28'd0, bus.cpu_memory_ready}, 32'h1);
    checkOutput("wrap_b_data3", {16'd0, dataOf(3)}, 32'h4444);
    tick();
    applyStimulus(4'b0000);
    checkOutput("wrap_c_data0", {16'd0, dataOf(0)}, 32'h2222);
    tick();

    // Reset one cycle after a grant to CPU1 (ptr=1).
    setAddr(1, 11'h050);
    applyStimulus(4'b0010);
    checkOutput("rstmid_ready", {28'd0, bus.cpu_memory_ready}, 32'h2);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("rstmid_rst_ready", {28'd0, bus.cpu_memory_ready}, 32'h0);
    checkOutput("rstmid_rst_en", {31'd0, bus.bram_en}, 32'd0);
    tick();
    rst = 1'b0;
    setAddr(0, 11'h010); setAddr(3, 11'h030);
    applyStimulus(4'b1001);
    checkOutput("rstmid_post_ready", {28'd0, bus.cpu_memory_ready}, 32'h0);
    checkOutput("rstmid_post_data1", {16'd0, dataOf(1)}, 32'h0);
    tick(); #1;
    checkOutput("rstmid_fresh_ready", {28'd0, bus.cpu_memory_ready}, 32'h1);
    checkOutput("rstmid_fresh_addr", {21'd0, bus.bram_addr}, 32'h010);
    tick();
    applyStimulus(4'b1000);
    checkOutput("rstmid_next_ready", {28'd0, bus.cpu_memory_ready}, 32'h8);
    checkOutput("rstmid_next_data0", {16'd0, dataOf(0)}, 32'h1111);
    tick();
    applyStimulus(4'b0000);
    checkOutput("rstmid_end_data3", {16'd0, dataOf(3)}, 32'h3333);
    tick();

    // Host write wins over CPU0/CPU3 requests (ptr=0).
    bus.host_wr_en   = 1'b1;
    bus.host_wr_addr = 11'h100;
    bus.host_wr_data = 16'hBEEF;
    applyStimulus(4'b1001);
    checkOutput("host_ready", {28'd0, bus.cpu_memory_ready}, 32'h0);
    checkOutput("host_we", {31'd0, bus.bram_we}, 32'd1);
    checkOutput("host_addr", {21'd0, bus.bram_addr}, 32'h100);
    checkOutput("host_wdata", {16'd0, bus.bram_wdata}, 32'hBEEF);
    tick();
    bus.host_wr_en = 1'b0;
    #1;
    checkOutput("host_h1_ready", {28'd0, bus.cpu_memory_ready}, 32'h1);
    tick();
    applyStimulus(4'b1000);
    checkOutput("host_h2_ready", {28'd0, bus.cpu_memory_ready}, 32'h8);
    checkOutput("host_h2_data0", {16'd0, dataOf(0)}, 32'h1111);
    tick();
    setAddr(2, 11'h100);
    applyStimulus(4'b0100);
    checkOutput("host_h3_data3", {16'd0, dataOf(3)}, 32'h3333);
    checkOutput("host_h3_ready", {28'd0, bus.cpu_memory_ready}, 32'h4);
    tick();
    applyStimulus(4'b0000);
    checkOutput("host_readback", {16'd0, dataOf(2)}, 32'hBEEF);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
